cacheline_burst_adapter: RTL
============================

# cacheline_burst_adapter

Bridges the L1 cache's 256-bit line interface to physical memory's 64-bit burst bus. Cache read misses (line fill) and dirty write-backs are each converted into a four-beat burst, and each completed line is returned in a single cycle. Sits directly downstream of the instruction/data cache datapath, which drives `cacheline_addr_in`/`cacheline_in` and consumes `cacheline_out`; memory (or the L1 arbiter) is on the far side.

## Interface
- `s_line`, 256: cache line width in bits.
- `s_beat`, 64: memory burst beat width in bits. `s_line/s_beat` = beats per burst, default 4.
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `line_read`  in  1  cache requests a line fill; held until `line_resp`.
- `line_write`  in  1  cache requests a line write-back; held until `line_resp`.
- `line_addr`  in  32  line address from the cache (`cacheline_addr_in`).
- `line_wdata`  in  s_line  line to write back (`cacheline_in`).
- `line_rdata`  out  s_line  assembled fill line (`cacheline_out`).
- `line_resp`  out  1  one-cycle completion pulse to the cache.
- `burst_read`  out  1  memory read burst request.
- `burst_write`  out  1  memory write burst request.
- `burst_addr`  out  32  burst base address; bits [4:0] always 0.
- `burst_wdata`  out  s_beat  current write beat.
- `burst_rdata`  in  s_beat  current read beat.
- `burst_resp`  in  1  memory accepted/delivered one beat this cycle.

## Operation
- The state machine has four states: IDLE, READ, WRITE, DONE. The beat counter `beat` is log2(beats) bits wide.
- **IDLE:**
  - On an edge with `line_write`=1: latch `{line_addr[31:5],5'b0}` and `line_wdata`, clear `beat`, go to WRITE.
  - Otherwise, on an edge with `line_read`=1: latch the address, clear `beat`, go to READ.
  - If both requests are high, write wins.
- **READ:**
  - `burst_read`=1 and `burst_addr` = latched address throughout.
  - On each edge with `burst_resp`=1, store `burst_rdata` into `line_rdata[s_beat*beat +: s_beat]` and increment `beat`.
  - On the edge that captures the last beat, go to DONE.
- **WRITE:**
  - `burst_write`=1 and `burst_wdata` = latched line word `[s_beat*beat +: s_beat]`.
  - On each edge with `burst_resp`=1, increment `beat`.
  - On the last beat, go to DONE.
- **DONE:** `line_resp`=1 for exactly one cycle; unconditionally return to IDLE.
- `line_rdata` holds its value from the last completed fill until the next READ overwrites it. Beats are written in place, so the line is partially updated during a READ.
- Requests from the cache are ignored outside IDLE. Changes to `line_addr`/`line_wdata` mid-burst have no effect, because both are latched on entry.
- `burst_read` and `burst_write` are never high simultaneously. Both are 0 in IDLE and DONE.
- Counter wrap-around: `beat` wraps to 0 after the last beat; it is not used again until re-cleared on entry.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from `line_*` or `burst_*` inputs to outputs.
- Reset value of every output is 0: `line_rdata`, `line_resp`, `burst_read`, `burst_write`, `burst_addr`, `burst_wdata`. The state resets to IDLE and `beat` to 0.
- Reset takes effect immediately on assertion, including mid-burst. The partial burst is abandoned and no `line_resp` is issued.
- Latency with zero-wait memory (`burst_resp` high every cycle of a burst):
  - Request sampled at edge E0.
  - `burst_read`/`burst_write` high in cycles E0..E4.
  - Beats transfer on edges E1..E4.
  - `line_resp` high in the cycle after E4.
  - IDLE again after E5.
- Total: 5 cycles from the sampling edge to the `line_resp` cycle. Each memory wait cycle (`burst_resp`=0) adds exactly one cycle.
- The cache must drop its request on the edge at which it sees `line_resp`. The adapter, back in IDLE, therefore never re-triggers on a stale request.
- Back-to-back transactions: minimum request-to-request spacing is 6 cycles. A write-back immediately followed by a fill (dirty eviction) needs no idle gap beyond the mandatory IDLE cycle.

## Test plan
- **Fill, zero-wait:** `line_read`, `line_addr`=0x1234_5678, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → `burst_addr`=0x1234_5660; `line_rdata`=0x44..44_33..33_22..22_11..11; `line_resp` a single pulse 5 cycles after the request edge.
- **Write-back with waits:** `line_write`, `line_wdata`=0xDDDD...AAAA (word 0 = 0xAAAA_AAAA_AAAA_AAAA), `burst_resp` low 2 cycles before each beat → `burst_wdata` presents words 0..3 in order, each held across its wait cycles; `line_resp` after 12 cycles in WRITE.
- **Simultaneous requests:** `line_read`=`line_write`=1 in IDLE → WRITE burst only, with `burst_read` never asserted.
- **Reset mid-fill:** drop `rst` after beat 2 of a READ → all outputs 0 immediately, no `line_resp`. A subsequent read of 0x0000_0040 completes normally.
- **Eviction sequence:** write-back to 0x0000_0100 immediately followed by a fill of 0x0000_0200 → two `line_resp` pulses. `burst_addr` is 0x100 for the write burst and 0x200 for the read burst, and the two bursts never overlap.
- **Request stability:** change `line_addr`/`line_wdata` during a burst → `burst_addr` and `burst_wdata` unaffected.

Source files
------------

// File: rtl/cacheline_burst_adapter_if.sv
// Cache-line / memory-burst signal bundle for cacheline_burst_adapter.
// master = cache + memory side, slave = the adapter itself.
interface cacheline_burst_adapter_if #(
    parameter int s_line = 256,
    parameter int s_beat = 64
);
    logic              line_read;
    logic              line_write;
    logic [31:0]       line_addr;
    logic [s_line-1:0] line_wdata;
    logic [s_line-1:0] line_rdata;
    logic              line_resp;
    logic              burst_read;
    logic              burst_write;
    logic [31:0]       burst_addr;
    logic [s_beat-1:0] burst_wdata;
    logic [s_beat-1:0] burst_rdata;
    logic              burst_resp;

    modport master (
        output line_read, line_write, line_addr, line_wdata,
        output burst_rdata, burst_resp,
        input  line_rdata, line_resp,
        input  burst_read, burst_write, burst_addr, burst_wdata
    );

    modport slave (
        input  line_read, line_write, line_addr, line_wdata,
        input  burst_rdata, burst_resp,
        output line_rdata, line_resp,
        output burst_read, burst_write, burst_addr, burst_wdata
    );
endinterface

// File: rtl/cacheline_burst_adapter.sv
// Converts 256-bit cache line fills/write-backs into 4-beat 64-bit bursts.
// All outputs come from registers or registered state only.
module cacheline_burst_adapter #(
    parameter int s_line = 256,
    parameter int s_beat = 64
) (
    input logic                      clk,
    input logic                      rst,
    cacheline_burst_adapter_if.slave bus
);
    localparam int BEATS = s_line / s_beat;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic [BEATS-1:0][s_beat-1:0] line_t;

    state_e        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [31:0]   addr_q, addr_d;
    line_t         wdata_q, wdata_d;
    line_t         rdata_q, rdata_d;
    logic          last_beat;

    assign last_beat = (beat_q == BW'(BEATS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Write-back takes priority when both requests arrive together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.line_write) begin
                    state_d = WRITE;
                end else if (bus.line_read) begin
                    state_d = READ;
                end
            end
            READ, WRITE: begin
                if (bus.burst_resp && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        beat_d  = beat_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.line_write || bus.line_read) begin
                    addr_d = {bus.line_addr[31:5], 5'b0};
                    beat_d = '0;
                end
                if (bus.line_write) begin
                    wdata_d = bus.line_wdata;
                end
            end
            READ: begin
                if (bus.burst_resp) begin
                    rdata_d[beat_q] = bus.burst_rdata;
                    beat_d          = beat_q + BW'(1);
                end
            end
            WRITE: begin
                if (bus.burst_resp) begin
                    beat_d = beat_q + BW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.burst_read  = (state_q == READ);
        bus.burst_write = (state_q == WRITE);
        bus.line_resp   = (state_q == DONE);
        bus.burst_addr  = addr_q;
        bus.burst_wdata = wdata_q[beat_q];
        bus.line_rdata  = rdata_q;
    end
endmodule
